mngr_arb: RTL
=============

Name: mngr_arb

Overview:
- Shares the single manager message channel between NCORE processor cores in a multicore build.
- Upstream (proc2mngr): arbitrates core requests round-robin onto one manager port, tagging each message with its source core ID.
- Downstream (mngr2proc): routes manager messages to the core named by a destination field.
- Both directions are val/rdy and each has a one-entry output buffer. It sits between the cores' proc2mngr/mngr2proc ports and the manager/testbench side.

Parameters:
- NCORE, 4, number of cores; 2..16.
- W, 32, message width in bits.
- IDW, $clog2(NCORE), source ID width (derived; do not override).
- DSTW, 8, width of the manager-supplied destination field.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- req_val  in  NCORE  per-core proc2mngr valid.
- req_rdy  out  NCORE  per-core proc2mngr ready.
- req_msg  in  NCORE*W  per-core proc2mngr message; core i occupies bits [i*W +: W].
- out_val  out  1  proc2mngr valid toward manager.
- out_rdy  in  1  manager ready.
- out_msg  out  W  granted message.
- out_src  out  IDW  source core ID of out_msg.
- in_val  in  1  mngr2proc valid from manager.
- in_rdy  out  1  ready toward manager.
- in_msg  in  W  manager message.
- in_dst  in  DSTW  destination core ID.
- core_val  out  NCORE  one-hot mngr2proc valid per core.
- core_rdy  in  NCORE  per-core mngr2proc ready.
- core_msg  out  W  mngr2proc data, shared by all cores.
- err  out  1  sticky flag: a message with an out-of-range destination was dropped.

Behaviour:
- A transfer occurs on a rising edge where val and rdy are both high on the same interface.

Reset (rst_n=0 at posedge):
- up_full=0, dn_full=0, ptr=0, err=0.
- out_msg=0, out_src=0, core_msg=0, dst_q=0.
- Any buffered message is discarded.
- Outputs hold these values until the first edge with rst_n=1.

Upstream arbitration:
- grant: one-hot, combinational. Pick the first i with req_val[i]=1, searching ptr, ptr+1, ... and wrapping modulo NCORE. grant=0 if no core requests.
- can_load = ~up_full | out_rdy.
- req_rdy[i] = grant[i] & can_load. At most one bit of req_rdy is high.
- On transfer from core i: out_msg<=req_msg[i], out_src<=i, up_full<=1, ptr<=(i+1) mod NCORE.
- out_val = up_full.
- If out_val & out_rdy with no new load: up_full<=0.
- Simultaneous drain and load: buffer reloads; up_full stays 1. Sustained throughput is 1 msg/cycle.
- Latency: out_val rises on the edge after acceptance.
- ptr changes only on an accepted transfer.
- out_msg/out_src are held stable while out_val=1 & out_rdy=0. Nothing is dropped or duplicated.

Downstream routing:
- dn_load = ~dn_full | core_rdy[dst_q].
- in_rdy = dn_load.
- On transfer:
  - If in_dst < NCORE: core_msg<=in_msg, dst_q<=in_dst, dn_full<=1.
  - Otherwise: the message is consumed, nothing is buffered (dn_full<=0 unless the buffer still holds an undrained message), and err<=1.
- core_val[i] = dn_full & (dst_q==i).
- If core_rdy[dst_q] is high with no new load: dn_full<=0.
- Simultaneous drain and load is allowed.
- Latency: 1 cycle.
- core_msg is held stable while stalled.
- err stays 1 until reset.

Independence:
- The two directions share no state.
- Upstream and downstream transfers may occur in the same cycle.

Test Plan:
1. Only core 2 asserts req_val with msg 0x00000075, out_rdy=1 -> req_rdy=0100. Next cycle out_val=1, out_msg=0x75, out_src=2, then ptr=3.
2. All four cores valid continuously with distinct msgs 0xA0..0xA3, out_rdy=1, from reset -> out_src sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
3. Core 1 message buffered, out_rdy=0 for 5 cycles while cores 0 and 3 request -> out_msg held, req_rdy=0000 throughout. After release: out_src=1, then 3, then 0.
4. in_msg=0x21, in_dst=1, core_rdy[1]=0 for 3 cycles -> core_val=0010 held, core_msg=0x21, in_rdy=0. Delivered on the cycle core_rdy[1]=1, and in_rdy rises the same cycle.
5. in_dst=5 (NCORE=4), in_val=1 -> in_rdy=1, core_val stays 0000, err=1 on the next cycle and stays 1 after further valid messages.
6. Both buffers full and ptr=2, then rst_n=0 for one edge -> out_val=0, core_val=0000, err=0. Then all cores request: the first grant goes to core 0.

Source files
------------

// File: rtl/mngr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mngr_arb
// Description : Shares one manager message channel between NCORE cores.
//               Upstream: round-robin arbitration of core requests into a
//               one-entry buffer, tagged with the source core ID.
//               Downstream: one-entry buffer routing manager messages to the
//               core named by the destination field; bad destinations are
//               consumed and raise a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mngr_arb #(
    parameter int NCORE = 4,
    parameter int W     = 32,
    parameter int IDW   = $clog2(NCORE),
    parameter int DSTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // proc2mngr, core side
    input  logic [NCORE-1:0]     req_val,
    output logic [NCORE-1:0]     req_rdy,
    input  logic [NCORE*W-1:0]   req_msg,
    // proc2mngr, manager side
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [W-1:0]         out_msg,
    output logic [IDW-1:0]       out_src,
    // mngr2proc, manager side
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [W-1:0]         in_msg,
    input  logic [DSTW-1:0]      in_dst,
    // mngr2proc, core side
    output logic [NCORE-1:0]     core_val,
    input  logic [NCORE-1:0]     core_rdy,
    output logic [W-1:0]         core_msg,
    output logic                 err
);

    // ------------------------------------------------------------------
    // Upstream state
    // ------------------------------------------------------------------
    logic               r_up_full;
    logic [IDW-1:0]     r_ptr;
    logic [W-1:0]       r_out_msg;
    logic [IDW-1:0]     r_out_src;

    logic [NCORE-1:0]   w_grant;
    logic [IDW-1:0]     w_gidx;
    logic               w_gfound;
    logic [W-1:0]       w_sel_msg;
    int                 w_idx;
    logic               w_can_load;
    logic               w_up_load;
    logic [IDW-1:0]     w_ptr_nxt;

    // ------------------------------------------------------------------
    // Downstream state
    // ------------------------------------------------------------------
    logic               r_dn_full;
    logic [IDW-1:0]     r_dst;
    logic [W-1:0]       r_core_msg;
    logic               r_err;

    logic               w_dst_rdy;
    logic               w_dn_load;
    logic               w_dn_xfer;
    logic               w_in_ok;

    // Round-robin search starting at r_ptr; first requesting core wins
    always_comb begin
        w_grant   = '0;
        w_gidx    = '0;
        w_gfound  = 1'b0;
        w_sel_msg = '0;
        w_idx     = 0;
        for (int k = 0; k < NCORE; k++) begin
            w_idx = (int'(r_ptr) + k) % NCORE;
            if (!w_gfound && req_val[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_gidx         = w_idx[IDW-1:0];
                w_gfound       = 1'b1;
                w_sel_msg      = req_msg[w_idx*W +: W];
            end
        end
    end

    // The buffer can accept when empty or when it is draining this cycle
    assign w_can_load = ~r_up_full | out_rdy;
    assign w_up_load  = w_gfound & w_can_load;
    assign req_rdy    = w_grant & {NCORE{w_can_load}};
    assign w_ptr_nxt  = (w_gidx == IDW'(NCORE - 1)) ? '0 : w_gidx + 1'b1;

    // Upstream buffer and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_up_full <= 1'b0;
            r_ptr     <= '0;
            r_out_msg <= '0;
            r_out_src <= '0;
        end else begin
            if (w_up_load) begin
                r_out_msg <= w_sel_msg;
                r_out_src <= w_gidx;
                r_up_full <= 1'b1;
                r_ptr     <= w_ptr_nxt;
            end else if (out_rdy) begin
                r_up_full <= 1'b0;
            end
        end
    end

    assign out_val = r_up_full;
    assign out_msg = r_out_msg;
    assign out_src = r_out_src;

    // Downstream: accept when empty or when the addressed core drains now
    assign w_dst_rdy = core_rdy[r_dst];
    assign w_dn_load = ~r_dn_full | w_dst_rdy;
    assign w_dn_xfer = in_val & w_dn_load;
    assign w_in_ok   = (in_dst < DSTW'(NCORE));
    assign in_rdy    = w_dn_load;

    // Downstream buffer, destination register and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dn_full  <= 1'b0;
            r_dst      <= '0;
            r_core_msg <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_dn_xfer) begin
                if (w_in_ok) begin
                    r_core_msg <= in_msg;
                    r_dst      <= in_dst[IDW-1:0];
                    r_dn_full  <= 1'b1;
                end else begin
                    // Bad destination: message is swallowed, buffer only
                    // keeps a message that has not yet been taken
                    r_err      <= 1'b1;
                    r_dn_full  <= r_dn_full & ~w_dst_rdy;
                end
            end else if (w_dst_rdy) begin
                r_dn_full <= 1'b0;
            end
        end
    end

    // One-hot valid toward the addressed core
    generate
        for (genvar gi = 0; gi < NCORE; gi++) begin : g_core_val
            assign core_val[gi] = r_dn_full & (r_dst == IDW'(gi));
        end
    endgenerate

    assign core_msg = r_core_msg;
    assign err      = r_err;

endmodule
`default_nettype wire
